cla_serial_adder: RTL and testbench

- Digit-serial WIDTH-bit adder that drives the team's 4-bit carry-lookahead adder `cla` one nibble per cycle.
- `cla` is the slice datapath. This block is the sequencing stage around it:
  - it accepts full-width operands over a valid/ready handshake;
  - it feeds the slice nibbles LSB-first and carries each slice's cout into the next slice's cin;
  - it assembles the full-width sum and presents it downstream over a second valid/ready handshake.
- It sits between an operand source (e.g. an ALU issue stage) and a result consumer.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla.sv | 30 +++
 rtl/cla_serial_adder.sv | 132 +++++++++++++
 tb/tb_cla_serial_adder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the digit-serial carry-lookahead adder.
// Slice width, sequencer state encoding and counter sizing helper.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice.
// Latency: combinational. Backpressure: none, pure datapath.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from g/p and cin so no carry ripples through the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit CLA slice per cycle, LSB nibble first.
// Latency: accept edge + NIB edges to out_valid. Backpressure: result held in DONE until out_ready.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_width_chk
        $fatal(1, "cla_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    localparam int            CW   = cnt_w(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic                 c_q, c_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic                 cout_q, cout_d;
    logic                 ovf_q, ovf_d;

    logic [SLICE_W-1:0]   sl_sum;
    logic                 sl_cout;

    cla u_cla (
        .a    (opa_q[SLICE_W-1:0]),
        .b    (opb_q[SLICE_W-1:0]),
        .cin  (c_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        c_d     = c_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    c_d     = cin;
                    idx_d   = '0;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                // Slice results enter at the top so the LSB nibble lands at the bottom after NIB shifts.
                sum_d = {sl_sum, sum_q[WIDTH-1:SLICE_W]};
                opa_d = opa_q >> SLICE_W;
                opb_d = opb_q >> SLICE_W;
                c_d   = sl_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = sl_cout;
                    ovf_d   = (sa_q == sb_q) && (sl_sum[SLICE_W-1] != sa_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder at WIDTH=16: scoreboard of arithmetic expectations
// checked on every valid output cycle, plus directed literal checks.
module tb_cla_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    int last_hs  = -1;
    bit spc_en   = 1'b0;

    logic [17:0] exp_q[$];

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] u;
        int          s;
        u = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        s = int'($signed(x)) + int'($signed(y)) + int'(ci);
        return {(s > 32767) || (s < -32768), u[16], u[15:0]};
    endfunction

    always @(posedge rst) exp_q.delete();

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                chk("result_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("sb_sum",  32'(sum),  32'(exp_q[0][15:0]));
                    chk("sb_cout", 32'(cout), 32'(exp_q[0][16]));
                    chk("sb_ovf",  32'(ovf),  32'(exp_q[0][17]));
                end
                if (out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (spc_en) begin
                        if (last_hs >= 0) chk("result_spacing", 32'(cyc - last_hs), 32'd6);
                        last_hs = cyc;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
        end
    end

    // Presents operands and returns #1 after the accept edge; in_valid is left high.
    task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic cc);
        int   n;
        logic rdy;
        a = aa; b = bb; cin = cc; in_valid = 1'b1;
        n = 0;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
    endtask

    // Returns the number of edges from the current point until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int hs0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);

        // Carry ripples through all four slices; out_valid four edges after the accept edge.
        send(16'hFFFF, 16'h0001, 1'b0);
        in_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        wait_valid(n);
        chk("t1_latency_edges", 32'(n), 32'd4);
        chk("t1_sum",  32'(sum),  32'h0000);
        chk("t1_cout", 32'(cout), 32'd1);
        chk("t1_ovf",  32'(ovf),  32'd0);
        @(posedge clk); #1;
        chk("t1_idle", 32'(in_ready), 32'd1);

        send(16'h7FFF, 16'h0001, 1'b0);
        in_valid = 1'b0;
        wait_valid(n);
        chk("t2a_sum",  32'(sum),  32'h8000);
        chk("t2a_cout", 32'(cout), 32'd0);
        chk("t2a_ovf",  32'(ovf),  32'd1);
        @(posedge clk); #1;

        send(16'h1234, 16'h4321, 1'b1);
        in_valid = 1'b0;
        wait_valid(n);
        chk("t2b_sum",  32'(sum),  32'h5556);
        chk("t2b_cout", 32'(cout), 32'd0);
        chk("t2b_ovf",  32'(ovf),  32'd0);
        @(posedge clk); #1;

        // Back-pressure: result held for 10 cycles, exactly one handshake.
        out_ready = 1'b0;
        send(16'h8000, 16'h8000, 1'b0);
        in_valid = 1'b0;
        wait_valid(n);
        hs0 = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("t3_sum",       32'(sum),       32'h0000);
            chk("t3_cout",      32'(cout),      32'd1);
            chk("t3_ovf",       32'(ovf),       32'd1);
            chk("t3_in_ready",  32'(in_ready),  32'd0);
            chk("t3_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk); #1;
        chk("t3_handshakes", 32'(hs_cnt - hs0), 32'd1);
        chk("t3_idle",       32'(in_ready),     32'd1);

        // Reset two cycles into RUN discards the operation.
        send(16'hFFFF, 16'hFFFF, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_sum",       32'(sum),       32'd0);
        chk("t4_busy",      32'(busy),      32'd0);
        chk("t4_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        send(16'h0005, 16'h0003, 1'b0);
        in_valid = 1'b0;
        wait_valid(n);
        chk("t4_sum_after", 32'(sum),  32'h0008);
        chk("t4_cout_after", 32'(cout), 32'd0);
        @(posedge clk); #1;

        // Back-to-back random operands with in_valid held high.
        hs0 = hs_cnt;
        last_hs = -1;
        spc_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk); #1;
        spc_en = 1'b0;
        chk("t5_results", 32'(hs_cnt - hs0), 32'd100);

        // in_valid toggling with different operands while busy must not disturb the result.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 8; i++) begin
            in_valid = i[0];
            a = 16'hAAAA ^ 16'(i);
            b = 16'h5555 + 16'(i);
            cin = ~i[1];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_valid(n);
        chk("t6_sum",  32'(sum),  32'h3333);
        chk("t6_cout", 32'(cout), 32'd0);
        chk("t6_ovf",  32'(ovf),  32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("t6_idle", 32'(in_ready), 32'd1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
